car_alarm_annunciator: RTL and testbench

//  Consumer end of the car-warning Alarm signal. Turns the combinational Alarm

---
 rtl/car_warn_pkg.sv | 23 ++
 rtl/car_alarm_annunciator_tick_gen.sv | 29 ++
 rtl/car_alarm_annunciator.sv | 180 ++++++++++++++++++
 tb/tb_car_alarm_annunciator.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/car_warn_pkg.sv
// Shared types for the car warning annunciator: FSM state encodings and sizing helpers.
package car_warn_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE     = 3'd0,
        ST_BEEP_ON  = 3'd1,
        ST_BEEP_OFF = 3'd2,
        ST_MUTED    = 3'd3,
        ST_CONT     = 3'd4
    } state_t;

    // Largest of three tick budgets, used to size the shared phase counter.
    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return m;
    endfunction

endpackage

// File: rtl/car_alarm_annunciator_tick_gen.sv
// Timing-tick prescaler: counts 0..TICK_DIV-1 and flags the wrap cycle; clr restarts the count.
module tick_gen #(
    parameter int unsigned TICK_DIV = 100
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int CNT_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_r;

    assign tick = (cnt_r == CNT_LAST);

    // Prescaler count; a clear restarts the phase so no partial tick carries over.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if (clr || tick) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_r + CNT_W'(1);
        end
    end

endmodule

// File: rtl/car_alarm_annunciator.sv
// Buzzer/lamp annunciator for the car-warning Alarm level with timed driver mute.
// Optional continuous-tone escalation is enabled by defining ANNUNCIATOR_ESCALATE_EN.
module car_alarm_annunciator
    import car_warn_pkg::*;
#(
    parameter int unsigned TICK_DIV   = 100,
    parameter int unsigned ON_TICKS   = 5,
    parameter int unsigned OFF_TICKS  = 5,
    parameter int unsigned MUTE_TICKS = 50
`ifdef ANNUNCIATOR_ESCALATE_EN
    ,
    parameter int unsigned ESC_BEEPS  = 8
`endif
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               alarm_req,
    input  logic               mute_btn,
    output logic               buzzer,
    output logic               lamp,
    output logic               muted,
    output logic [STATE_W-1:0] state_o
);

    localparam int PH_W = $clog2(max3(ON_TICKS, OFF_TICKS, MUTE_TICKS) + 1);
    localparam logic [PH_W-1:0] ON_LAST   = PH_W'(ON_TICKS - 1);
    localparam logic [PH_W-1:0] OFF_LAST  = PH_W'(OFF_TICKS - 1);
    localparam logic [PH_W-1:0] MUTE_LAST = PH_W'(MUTE_TICKS - 1);

    logic            req_meta_r, req_s;
    logic            mute_meta_r, mute_s, mute_s_d;
    logic            mute_pe;
    logic            tick;
    logic            tick_clr_s;
    state_t          state_r, state_nx;
    logic [PH_W-1:0] phase_r;

`ifdef ANNUNCIATOR_ESCALATE_EN
    localparam int BEEP_W = $clog2(ESC_BEEPS + 1);
    localparam logic [BEEP_W-1:0] BEEP_MAX = BEEP_W'(ESC_BEEPS);

    logic [BEEP_W-1:0] beep_cnt_r, beep_nx_s;

    assign beep_nx_s = (beep_cnt_r == BEEP_MAX) ? BEEP_MAX : beep_cnt_r + BEEP_W'(1);
`endif

    // Two-flop synchronisers for the asynchronous request and the raw button.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_meta_r  <= 1'b0;
            req_s       <= 1'b0;
            mute_meta_r <= 1'b0;
            mute_s      <= 1'b0;
            mute_s_d    <= 1'b0;
        end else begin
            req_meta_r  <= alarm_req;
            req_s       <= req_meta_r;
            mute_meta_r <= mute_btn;
            mute_s      <= mute_meta_r;
            mute_s_d    <= mute_s;
        end
    end

    assign mute_pe = mute_s & ~mute_s_d;

    // Restarting the prescaler on every state change gives each phase its full length.
    assign tick_clr_s = (state_r == ST_IDLE) || (state_nx != state_r);

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (tick_clr_s),
        .tick  (tick)
    );

    // Next-state: request drop beats mute, mute beats the phase timers.
    always_comb begin
        state_nx = state_r;
        if (state_r == ST_IDLE) begin
            if (req_s) begin
                state_nx = ST_BEEP_ON;
            end else begin
                state_nx = ST_IDLE;
            end
        end else if (!req_s) begin
            state_nx = ST_IDLE;
        end else if (mute_pe && (state_r != ST_MUTED)) begin
            state_nx = ST_MUTED;
        end else begin
            case (state_r)
                ST_BEEP_ON: begin
                    if (tick && (phase_r == ON_LAST)) begin
`ifdef ANNUNCIATOR_ESCALATE_EN
                        state_nx = (beep_nx_s == BEEP_MAX) ? ST_CONT : ST_BEEP_OFF;
`else
                        state_nx = ST_BEEP_OFF;
`endif
                    end else begin
                        state_nx = ST_BEEP_ON;
                    end
                end
                ST_BEEP_OFF: begin
                    if (tick && (phase_r == OFF_LAST)) begin
                        state_nx = ST_BEEP_ON;
                    end else begin
                        state_nx = ST_BEEP_OFF;
                    end
                end
                ST_MUTED: begin
                    if (tick && (phase_r == MUTE_LAST)) begin
`ifdef ANNUNCIATOR_ESCALATE_EN
                        state_nx = (beep_cnt_r == BEEP_MAX) ? ST_CONT : ST_BEEP_ON;
`else
                        state_nx = ST_BEEP_ON;
`endif
                    end else begin
                        state_nx = ST_MUTED;
                    end
                end
`ifdef ANNUNCIATOR_ESCALATE_EN
                ST_CONT: begin
                    state_nx = ST_CONT;
                end
`endif
                default: begin
                    state_nx = ST_IDLE;
                end
            endcase
        end
    end

    // FSM register, phase/beep counters and output drivers decoded from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            phase_r <= '0;
            buzzer  <= 1'b0;
            lamp    <= 1'b0;
            muted   <= 1'b0;
`ifdef ANNUNCIATOR_ESCALATE_EN
            beep_cnt_r <= '0;
`endif
        end else begin
            state_r <= state_nx;

            if (state_nx != state_r) begin
                phase_r <= '0;
            end else if (tick && (state_r != ST_IDLE) && (state_r != ST_CONT)) begin
                phase_r <= phase_r + PH_W'(1);
            end else begin
                phase_r <= phase_r;
            end

`ifdef ANNUNCIATOR_ESCALATE_EN
            if (state_nx == ST_IDLE) begin
                beep_cnt_r <= '0;
            end else if ((state_r == ST_BEEP_ON) &&
                         ((state_nx == ST_BEEP_OFF) || (state_nx == ST_CONT))) begin
                beep_cnt_r <= beep_nx_s;
            end else begin
                beep_cnt_r <= beep_cnt_r;
            end
`endif

            case (state_nx)
                ST_IDLE:     begin buzzer <= 1'b0; lamp <= 1'b0; muted <= 1'b0; end
                ST_BEEP_ON:  begin buzzer <= 1'b1; lamp <= 1'b1; muted <= 1'b0; end
                ST_BEEP_OFF: begin buzzer <= 1'b0; lamp <= 1'b1; muted <= 1'b0; end
                ST_MUTED:    begin buzzer <= 1'b0; lamp <= 1'b1; muted <= 1'b1; end
                ST_CONT:     begin buzzer <= 1'b1; lamp <= 1'b1; muted <= 1'b0; end
                default:     begin buzzer <= 1'b0; lamp <= 1'b0; muted <= 1'b0; end
            endcase
        end
    end

    assign state_o = state_r;

endmodule

// File: tb/tb_car_alarm_annunciator.sv
// Directed self-checking bench for car_alarm_annunciator (TICK_DIV=4, ON=2, OFF=2, MUTE=6, ESC=3).
module tb_car_alarm_annunciator;

    logic       clk;
    logic       rst_n;
    logic       alarm_req;
    logic       mute_btn;
    logic       buzzer;
    logic       lamp;
    logic       muted;
    logic [2:0] state_o;

    int total;
    int bad;

    car_alarm_annunciator #(
        .TICK_DIV   (4),
        .ON_TICKS   (2),
        .OFF_TICKS  (2),
        .MUTE_TICKS (6)
`ifdef ANNUNCIATOR_ESCALATE_EN
        ,
        .ESC_BEEPS  (3)
`endif
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .alarm_req (alarm_req),
        .mute_btn  (mute_btn),
        .buzzer    (buzzer),
        .lamp      (lamp),
        .muted     (muted),
        .state_o   (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected {state_o, buzzer, lamp, muted} for a given state number.
    function automatic logic [5:0] exp_vec(input int st);
        case (st)
            0:       return 6'b000_000;
            1:       return 6'b001_110;
            2:       return 6'b010_010;
            3:       return 6'b011_011;
            4:       return 6'b100_110;
            default: return 6'b000_000;
        endcase
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; alarm_req = 1'b0; mute_btn = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({state_o, buzzer, lamp, muted} !== 6'b000_000) begin
            bad++;
            $display("FAIL reset_held got=%b want=%b", {state_o, buzzer, lamp, muted}, 6'b000_000);
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({state_o, buzzer, lamp, muted} !== 6'b000_000) begin
            bad++;
            $display("FAIL reset_idle got=%b want=%b", {state_o, buzzer, lamp, muted}, 6'b000_000);
        end
    endtask

    task automatic test_return_idle(input string name);
        alarm_req = 1'b0; mute_btn = 1'b0;
        repeat (4) @(negedge clk);
        total++;
        if ({state_o, buzzer, lamp, muted} !== 6'b000_000) begin
            bad++;
            $display("FAIL %s_idle got=%b want=%b", name, {state_o, buzzer, lamp, muted}, 6'b000_000);
        end
    endtask

    task automatic test_beep();
        int st;
        alarm_req = 1'b1;
        for (int k = 1; k <= 28; k++) begin
            @(negedge clk);
            st = (k < 3) ? 0 : ((((k - 3) / 8) % 2) == 0 ? 1 : 2);
            total++;
            if ({state_o, buzzer, lamp, muted} !== exp_vec(st)) begin
                bad++;
                $display("FAIL beep k=%0d got=%b want=%b", k, {state_o, buzzer, lamp, muted}, exp_vec(st));
            end
        end
        test_return_idle("beep");
    endtask

    task automatic test_mute();
        int st;
        alarm_req = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k < 3)       st = 0;
            else if (k < 7)  st = 1;
            else if (k < 31) st = 3;
            else if (k < 39) st = 1;
            else             st = 2;
            total++;
            if ({state_o, buzzer, lamp, muted} !== exp_vec(st)) begin
                bad++;
                $display("FAIL mute k=%0d got=%b want=%b", k, {state_o, buzzer, lamp, muted}, exp_vec(st));
            end
            if (k == 4)  mute_btn = 1'b1;
            if (k == 6)  mute_btn = 1'b0;
            if (k == 12) mute_btn = 1'b1;
            if (k == 14) mute_btn = 1'b0;
        end
        test_return_idle("mute");
    endtask

    task automatic test_drop();
        int st;
        alarm_req = 1'b1;
        for (int k = 1; k <= 34; k++) begin
            @(negedge clk);
            if (k < 3)       st = 0;
            else if (k < 11) st = 1;
            else if (k < 16) st = 2;
            else if (k < 23) st = 0;
            else if (k < 31) st = 1;
            else             st = 2;
            total++;
            if ({state_o, buzzer, lamp, muted} !== exp_vec(st)) begin
                bad++;
                $display("FAIL drop k=%0d got=%b want=%b", k, {state_o, buzzer, lamp, muted}, exp_vec(st));
            end
            if (k == 13) alarm_req = 1'b0;
            if (k == 20) alarm_req = 1'b1;
        end
        test_return_idle("drop");
    endtask

    task automatic test_mute_tick();
        int st;
        alarm_req = 1'b1;
        for (int k = 1; k <= 46; k++) begin
            @(negedge clk);
            if (k < 3)       st = 0;
            else if (k < 11) st = 1;
            else if (k < 19) st = 2;
            else if (k < 43) st = 3;
            else             st = 1;
            total++;
            if ({state_o, buzzer, lamp, muted} !== exp_vec(st)) begin
                bad++;
                $display("FAIL mute_tick k=%0d got=%b want=%b", k, {state_o, buzzer, lamp, muted}, exp_vec(st));
            end
            if (k == 16) mute_btn = 1'b1;
            if (k == 18) mute_btn = 1'b0;
        end
        test_return_idle("mute_tick");
    endtask

    task automatic test_rst_mid();
        int st;
        alarm_req = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k < 3)       st = 0;
            else if (k < 6)  st = 1;
            else if (k < 10) st = 0;
            else if (k < 18) st = 1;
            else             st = 2;
            total++;
            if ({state_o, buzzer, lamp, muted} !== exp_vec(st)) begin
                bad++;
                $display("FAIL rst_mid k=%0d got=%b want=%b", k, {state_o, buzzer, lamp, muted}, exp_vec(st));
            end
            if (k == 5) begin
                rst_n = 1'b0;
                #1;
                total++;
                if ({state_o, buzzer, lamp, muted} !== 6'b000_000) begin
                    bad++;
                    $display("FAIL rst_async got=%b want=%b", {state_o, buzzer, lamp, muted}, 6'b000_000);
                end
            end
            if (k == 7) rst_n = 1'b1;
        end
        test_return_idle("rst_mid");
    endtask

`ifdef ANNUNCIATOR_ESCALATE_EN
    task automatic test_escalate();
        int st;
        alarm_req = 1'b1;
        for (int k = 1; k <= 80; k++) begin
            @(negedge clk);
            if (k < 3)       st = 0;
            else if (k < 43) st = ((((k - 3) / 8) % 2) == 0) ? 1 : 2;
            else if (k < 53) st = 4;
            else if (k < 77) st = 3;
            else             st = 4;
            total++;
            if ({state_o, buzzer, lamp, muted} !== exp_vec(st)) begin
                bad++;
                $display("FAIL escalate k=%0d got=%b want=%b", k, {state_o, buzzer, lamp, muted}, exp_vec(st));
            end
            if (k == 50) mute_btn = 1'b1;
            if (k == 52) mute_btn = 1'b0;
        end
        test_return_idle("escalate");
    endtask
`endif

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_beep();
        test_mute();
        test_drop();
        test_mute_tick();
        test_rst_mid();
`ifdef ANNUNCIATOR_ESCALATE_EN
        test_escalate();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
